// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the digit width, the default refresh constant and the nibble type.
// No ports; imported by ssd_scan_prescaler and ssd_scanner.
package ssd_pkg;
  localparam int DIGIT_W          = 4;
  localparam int SSD_PRESCALE_DEF = 50000;

  typedef logic [DIGIT_W-1:0] nibble_t;
endpackage

// File: rtl/ssd_scan_prescaler.sv
// Refresh-rate prescaler: free-running counter 0..PRESCALE-1 that marks slot ends.
// Ports: clk, rst (async active-high), tick (high for the single cycle cnt == PRESCALE-1).
// tick is decoded from the registered count, so it is glitch-free within a cycle.
module ssd_scan_prescaler
  import ssd_pkg::*;
#(
  parameter int PRESCALE = SSD_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ssd_scanner.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Ports: clk, rst (async active-high), load/value (double-buffered capture),
//        digit_data (active nibble), digit_en_n (one-cold enable), frame_done (wrap pulse).
// Optional macro SSD_SCAN_LZB_EN enables leading-zero blanking of digits above digit 0.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = SSD_PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output nibble_t               digit_data,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  frame_done
);
  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE  = {{(DIGITS-1){1'b0}}, 1'b1};

  logic                  tick;
  logic [IW-1:0]         idx, idx_nxt;
  logic                  wrap;
  logic [4*DIGITS-1:0]   display, display_nxt, pending;
  logic                  pending_valid;
  nibble_t               nib_nxt;
  logic [DIGITS-1:0]     en_n_nxt;
  logic                  blank;

  ssd_scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Outputs are registered from next-state values so the enable and the
  // nibble change on the same edge that advances the digit index.
  always_comb begin
    idx_nxt     = idx;
    wrap        = 1'b0;
    display_nxt = display;
    blank       = 1'b0;

    if (tick) begin
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
        wrap    = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end

    // A load in the wrap cycle bypasses pending so it is not lost for a frame.
    if (wrap) begin
      if (load) begin
        display_nxt = value;
      end else if (pending_valid) begin
        display_nxt = pending;
      end
    end

    nib_nxt = display_nxt[DIGIT_W*idx_nxt +: DIGIT_W];

`ifdef SSD_SCAN_LZB_EN
    // Blank when this nibble and every higher one are zero; digit 0 always shows.
    blank = (idx_nxt != '0) && ((display_nxt >> (DIGIT_W*idx_nxt)) == '0);
`endif

    en_n_nxt = blank ? '1 : ~(ONE << idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      digit_data    <= '0;
      digit_en_n    <= '1;
      frame_done    <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      display <= display_nxt;
      if (load) begin
        pending <= value;
      end
      if (wrap) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
      digit_data <= nib_nxt;
      digit_en_n <= en_n_nxt;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_ssd_scanner.sv
// Directed bench for ssd_scanner with DIGITS = 4, PRESCALE = 4.
// Edge k after reset release: idx = (k/4)%4, frame_done after edges k = 16, 32, ...
// Expected display contents are written per phase as hand-picked constants.
module tb_ssd_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_data;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  ssd_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .digit_data (digit_data),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Advance one edge, then check outputs against the expected displayed value.
  task automatic step(input logic [15:0] disp);
    int          i;
    logic [3:0]  en_exp;
    logic [3:0]  nib;
    @(posedge clk);
    #1;
    k++;
    i = (k / 4) % 4;
    nib = disp[4*i +: 4];
    en_exp = ~(4'b0001 << i);
`ifdef SSD_SCAN_LZB_EN
    if (i != 0 && (disp >> (4*i)) == 16'h0) en_exp = 4'b1111;
`endif
    check4("digit_en_n", digit_en_n, en_exp);
    check4("digit_data", digit_data, nib);
    check1("frame_done", frame_done, (k % 16) == 0);
  endtask

  task automatic run_to(input int last, input logic [15:0] disp);
    while (k < last) step(disp);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check4("rst_en_n", digit_en_n, 4'b1111);
    check4("rst_data", digit_data, 4'h0);
    check1("rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    k = 0;

    // Scan from reset: 0 everywhere, frame_done at 16
    run_to(21, 16'h0000);

    // Load mid-frame in digit 1's slot; shows from the next frame
    load = 1'b1; value = 16'hA3F5;
    step(16'h0000);
    load = 1'b0; value = 16'h0;
    run_to(31, 16'h0000);
    run_to(47, 16'hA3F5);

    // Double load in one frame: last value wins
    run_to(49, 16'hA3F5);
    load = 1'b1; value = 16'h1111;
    step(16'hA3F5);
    load = 1'b0;
    run_to(52, 16'hA3F5);
    load = 1'b1; value = 16'h2222;
    step(16'hA3F5);
    load = 1'b0; value = 16'h0;
    run_to(63, 16'hA3F5);
    run_to(79, 16'h2222);

    // Load in the exact wrap cycle: bypass into the frame starting now
    load = 1'b1; value = 16'h3333;
    step(16'h3333);
    load = 1'b0; value = 16'h0;
    run_to(88, 16'h3333);

    // Reset mid-scan in digit 2's slot, one cycle after a pending load
    load = 1'b1; value = 16'h7777;
    step(16'h3333);
    load = 1'b0; value = 16'h0;
    step(16'h3333);
    rst = 1'b1;
    #1;
    check4("midrst_en_n", digit_en_n, 4'b1111);
    check4("midrst_data", digit_data, 4'h0);
    check1("midrst_fd", frame_done, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    // Dropped pending must not appear at the wrap
    run_to(21, 16'h0000);

    // Leading-zero cases (blanking expectation depends on the build)
    load = 1'b1; value = 16'h0042;
    step(16'h0000);
    load = 1'b0; value = 16'h0;
    run_to(31, 16'h0000);
    run_to(49, 16'h0042);
    load = 1'b1; value = 16'h0000;
    step(16'h0042);
    load = 1'b0;
    run_to(63, 16'h0042);
    run_to(80, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
